// File: rtl/multicycle_control_if.sv
// Control bundle between IR/decode fields, shared memory handshake and datapath.
// master = control FSM side, slave = datapath/memory side.
interface multicycle_control_if #(
    parameter int ALU_SEL_W = 4
);
    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic                 funct7_5;
    logic                 zero;
    logic                 mem_ready;
    logic                 pc_write;
    logic                 ir_write;
    logic                 adr_src;
    logic                 mem_read;
    logic                 mem_write;
    logic                 reg_write;
    logic [1:0]           alu_src_a;
    logic [1:0]           alu_src_b;
    logic [1:0]           result_src;
    logic [ALU_SEL_W-1:0] alu_sel;
    logic                 illegal;
    logic                 mem_timeout;
    logic [3:0]           state_dbg;

    modport master (
        input  opcode, funct3, funct7_5, zero, mem_ready,
        output pc_write, ir_write, adr_src, mem_read, mem_write,
        output reg_write, alu_src_a, alu_src_b, result_src,
        output alu_sel, illegal, mem_timeout, state_dbg
    );

    modport slave (
        output opcode, funct3, funct7_5, zero, mem_ready,
        input  pc_write, ir_write, adr_src, mem_read, mem_write,
        input  reg_write, alu_src_a, alu_src_b, result_src,
        input  alu_sel, illegal, mem_timeout, state_dbg
    );
endinterface

// File: rtl/multicycle_control.sv
// Multi-cycle RV32I control FSM: fetch/decode/execute/memory/writeback
// sequencing with memory ready handshake, illegal-op and timeout traps.
module multicycle_control #(
    parameter int ALU_SEL_W   = 4,
    parameter int MEM_TIMEOUT = 16,
    parameter int SUPPORT_JAL = 1
) (
    input  logic clk,
    input  logic reset,
    multicycle_control_if.master bus
);
    typedef enum logic [3:0] {
        S_FETCH   = 4'd0,
        S_DECODE  = 4'd1,
        S_MEM_ADR = 4'd2,
        S_MEM_RD  = 4'd3,
        S_MEM_WB  = 4'd4,
        S_MEM_WR  = 4'd5,
        S_EXEC_R  = 4'd6,
        S_EXEC_I  = 4'd7,
        S_ALU_WB  = 4'd8,
        S_BEQ     = 4'd9,
        S_JAL     = 4'd10,
        S_TRAP    = 4'd11
    } state_t;

    localparam int CW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
    localparam logic [CW-1:0] CNT_LAST = CW'(MEM_TIMEOUT - 1);

    localparam logic [6:0] OP_LW  = 7'b0000011;
    localparam logic [6:0] OP_SW  = 7'b0100011;
    localparam logic [6:0] OP_R   = 7'b0110011;
    localparam logic [6:0] OP_I   = 7'b0010011;
    localparam logic [6:0] OP_BR  = 7'b1100011;
    localparam logic [6:0] OP_JAL = 7'b1101111;

    localparam logic [3:0] ALU_AND = 4'b0000;
    localparam logic [3:0] ALU_OR  = 4'b0001;
    localparam logic [3:0] ALU_ADD = 4'b0010;
    localparam logic [3:0] ALU_XOR = 4'b0011;
    localparam logic [3:0] ALU_SUB = 4'b0110;
    localparam logic [3:0] ALU_SLT = 4'b0111;

    state_t        state, state_next;
    logic [CW-1:0] cnt;
    logic          illegal_q, timeout_q;
    logic          set_ill, set_to;
    logic          f3_ok, wait_hit;
    logic [3:0]    dec_sel, alu_code;
    logic          pc_write, ir_write, adr_src;
    logic          mem_read, mem_write, reg_write;
    logic [1:0]    src_a, src_b, res_src;

    always_comb begin
        f3_ok   = 1'b1;
        dec_sel = ALU_ADD;
        case (bus.funct3)
            3'b000: dec_sel = (bus.opcode == OP_R && bus.funct7_5)
                              ? ALU_SUB : ALU_ADD;
            3'b111: dec_sel = ALU_AND;
            3'b110: dec_sel = ALU_OR;
            3'b100: dec_sel = ALU_XOR;
            3'b010: dec_sel = ALU_SLT;
            default: f3_ok = 1'b0;
        endcase
    end

    // Final allowed wait cycle without ready traps; ready on it still wins.
    assign wait_hit = (cnt == CNT_LAST) && !bus.mem_ready;

    always_comb begin
        state_next = state;
        set_ill    = 1'b0;
        set_to     = 1'b0;
        pc_write   = 1'b0;
        ir_write   = 1'b0;
        adr_src    = 1'b0;
        mem_read   = 1'b0;
        mem_write  = 1'b0;
        reg_write  = 1'b0;
        src_a      = 2'b00;
        src_b      = 2'b00;
        res_src    = 2'b00;
        alu_code   = ALU_ADD;
        case (state)
            S_FETCH: begin
                mem_read = 1'b1;
                src_b    = 2'b10;
                res_src  = 2'b10;
                if (bus.mem_ready) begin
                    ir_write   = 1'b1;
                    pc_write   = 1'b1;
                    state_next = S_DECODE;
                end else if (wait_hit) begin
                    set_to     = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_DECODE: begin
                src_a = 2'b01;
                src_b = 2'b01;
                unique case (1'b1)
                    (bus.opcode == OP_LW || bus.opcode == OP_SW):
                        state_next = S_MEM_ADR;
                    (bus.opcode == OP_R && f3_ok):
                        state_next = S_EXEC_R;
                    (bus.opcode == OP_I && f3_ok):
                        state_next = S_EXEC_I;
                    (bus.opcode == OP_BR && bus.funct3 == 3'b000):
                        state_next = S_BEQ;
                    (SUPPORT_JAL != 0 && bus.opcode == OP_JAL):
                        state_next = S_JAL;
                    default: begin
                        set_ill    = 1'b1;
                        state_next = S_TRAP;
                    end
                endcase
            end
            S_MEM_ADR: begin
                src_a      = 2'b10;
                src_b      = 2'b01;
                state_next = (bus.opcode == OP_LW) ? S_MEM_RD : S_MEM_WR;
            end
            S_MEM_RD: begin
                mem_read = 1'b1;
                adr_src  = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_MEM_WB;
                end else if (wait_hit) begin
                    set_to     = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_MEM_WB: begin
                res_src    = 2'b01;
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_MEM_WR: begin
                mem_write = 1'b1;
                adr_src   = 1'b1;
                if (bus.mem_ready) begin
                    state_next = S_FETCH;
                end else if (wait_hit) begin
                    set_to     = 1'b1;
                    state_next = S_TRAP;
                end
            end
            S_EXEC_R: begin
                src_a      = 2'b10;
                alu_code   = dec_sel;
                state_next = S_ALU_WB;
            end
            S_EXEC_I: begin
                src_a      = 2'b10;
                src_b      = 2'b01;
                alu_code   = dec_sel;
                state_next = S_ALU_WB;
            end
            S_ALU_WB: begin
                reg_write  = 1'b1;
                state_next = S_FETCH;
            end
            S_BEQ: begin
                src_a      = 2'b10;
                alu_code   = ALU_SUB;
                pc_write   = bus.zero;
                state_next = S_FETCH;
            end
            S_JAL: begin
                src_a      = 2'b01;
                src_b      = 2'b10;
                pc_write   = 1'b1;
                state_next = S_ALU_WB;
            end
            S_TRAP: state_next = S_TRAP;
            default: state_next = S_FETCH;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= S_FETCH;
            cnt       <= '0;
            illegal_q <= 1'b0;
            timeout_q <= 1'b0;
        end else begin
            state     <= state_next;
            cnt       <= (state_next == state && state != S_TRAP)
                         ? cnt + CW'(1) : '0;
            illegal_q <= illegal_q | set_ill;
            timeout_q <= timeout_q | set_to;
        end
    end

    assign bus.pc_write    = pc_write;
    assign bus.ir_write    = ir_write;
    assign bus.adr_src     = adr_src;
    assign bus.mem_read    = mem_read;
    assign bus.mem_write   = mem_write;
    assign bus.reg_write   = reg_write;
    assign bus.alu_src_a   = src_a;
    assign bus.alu_src_b   = src_b;
    assign bus.result_src  = res_src;
    assign bus.alu_sel     = ALU_SEL_W'(alu_code);
    assign bus.illegal     = illegal_q;
    assign bus.mem_timeout = timeout_q;
    assign bus.state_dbg   = state;
endmodule
